// File: rtl/pipeline_processor_pkg.sv
// Shared definitions for the 5-stage pipeline core:
// opcodes, instruction field positions and stage instruction classes.
package pipeline_processor_pkg;

   localparam int OP_HI  = 31;
   localparam int OP_LO  = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;
   localparam int RD_HI  = 15;
   localparam int RD_LO  = 11;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   localparam logic [5:0] OP_ADD   = 6'd0;
   localparam logic [5:0] OP_SUB   = 6'd1;
   localparam logic [5:0] OP_AND   = 6'd2;
   localparam logic [5:0] OP_OR    = 6'd3;
   localparam logic [5:0] OP_SLT   = 6'd4;
   localparam logic [5:0] OP_MUL   = 6'd5;
   localparam logic [5:0] OP_LW    = 6'd8;
   localparam logic [5:0] OP_SW    = 6'd9;
   localparam logic [5:0] OP_ADDI  = 6'd10;
   localparam logic [5:0] OP_SUBI  = 6'd11;
   localparam logic [5:0] OP_SLTI  = 6'd12;
   localparam logic [5:0] OP_BNEQZ = 6'd13;
   localparam logic [5:0] OP_BEQZ  = 6'd14;
   localparam logic [5:0] OP_HLT   = 6'd63;

   // Opcode 6 is unassigned, so this word decodes as a bubble
   localparam logic [31:0] NOP_IR = 32'h1800_0000;

   typedef enum logic [2:0] {
      RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP
   } itype_t;

   function automatic itype_t decode_type(input logic [5:0] op);
      itype_t t;
      unique case (1'b1)
         (op <= OP_MUL):                      t = RR_ALU;
         (op == OP_LW):                       t = LOAD;
         (op == OP_SW):                       t = STORE;
         (op >= OP_ADDI) && (op <= OP_SLTI):  t = RM_ALU;
         (op == OP_BNEQZ) || (op == OP_BEQZ): t = BRANCH;
         (op == OP_HLT):                      t = HALT;
         default:                             t = NOP;
      endcase
      return t;
   endfunction

   function automatic logic [31:0] sext(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/pipeline_alu.sv
// Combinational execute-stage ALU: opcode plus two operands
// gives a 32-bit result; address adds take the default path.
module pipeline_alu
   import pipeline_processor_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result
);

   // Select the operation; arithmetic wraps modulo 2^32
   always_comb begin
      unique case (1'b1)
         (op == OP_ADD) || (op == OP_ADDI):
            result = a + b;
         (op == OP_SUB) || (op == OP_SUBI):
            result = a - b;
         (op == OP_AND):
            result = a & b;
         (op == OP_OR):
            result = a | b;
         (op == OP_SLT) || (op == OP_SLTI):
            result = {31'd0, $signed(a) < $signed(b)};
         (op == OP_MUL):
            result = a * b;
         default:
            result = a + b;
      endcase
   end

endmodule

// File: rtl/pipeline_processor.sv
// Five-stage in-order core with EX forwarding, EX-resolved
// branches and ID-decoded halt; Reg/Mem survive reset.
module pipeline_processor
   import pipeline_processor_pkg::*;
(
   input  logic clk1,
   input  logic rst_n,
   output logic halted
);

   logic [31:0] Reg [0:31];
   logic [31:0] Mem [0:1023];
   logic [31:0] PC;
   logic        HALTED;
   logic        TAKEN_BRANCH;
   logic        stop_fetch;

   logic [31:0] if_id_ir;
   logic [31:0] if_id_npc;

   itype_t      id_ex_type;
   logic [5:0]  id_ex_op;
   logic [4:0]  id_ex_rs;
   logic [4:0]  id_ex_rt;
   logic [4:0]  id_ex_dst;
   logic [31:0] id_ex_a;
   logic [31:0] id_ex_b;
   logic [31:0] id_ex_imm;
   logic [31:0] id_ex_npc;

   itype_t      ex_mem_type;
   logic [4:0]  ex_mem_dst;
   logic [31:0] ex_mem_alu;
   logic [31:0] ex_mem_b;

   itype_t      mem_wb_type;
   logic [4:0]  mem_wb_dst;
   logic [31:0] mem_wb_val;

   logic [5:0]  id_op;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic [4:0]  id_dst;
   itype_t      id_type;
   logic [31:0] id_a;
   logic [31:0] id_b;

   logic [31:0] fa;
   logic [31:0] fb;
   logic [31:0] alu_b;
   logic [31:0] alu_res;
   logic [31:0] br_target;
   logic        br_taken;
   logic        ex_fwd_ok;

   assign halted  = HALTED;
   assign id_op   = if_id_ir[OP_HI:OP_LO];
   assign id_rs   = if_id_ir[RS_HI:RS_LO];
   assign id_rt   = if_id_ir[RT_HI:RT_LO];
   assign id_rd   = if_id_ir[RD_HI:RD_LO];
   assign id_type = decode_type(id_op);

   // Destination register; zero means the instruction writes nothing
   always_comb begin
      unique case (1'b1)
         (id_type == RR_ALU):
            id_dst = id_rd;
         (id_type == RM_ALU) || (id_type == LOAD):
            id_dst = id_rt;
         default:
            id_dst = '0;
      endcase
   end

   // Register read with write-through from the WB stage
   always_comb begin
      id_a = Reg[id_rs];
      id_b = Reg[id_rt];
      if (mem_wb_dst != '0 && mem_wb_dst == id_rs) id_a = mem_wb_val;
      if (mem_wb_dst != '0 && mem_wb_dst == id_rt) id_b = mem_wb_val;
      if (id_rs == '0) id_a = '0;
      if (id_rt == '0) id_b = '0;
   end

   // A load's EX/MEM value is still an address, never forwarded
   assign ex_fwd_ok = (ex_mem_dst != '0) && (ex_mem_type != LOAD);

   // Operand forwarding; the younger EX/MEM result wins over MEM/WB
   always_comb begin
      fa = id_ex_a;
      fb = id_ex_b;
      if (mem_wb_dst != '0 && mem_wb_dst == id_ex_rs) fa = mem_wb_val;
      if (mem_wb_dst != '0 && mem_wb_dst == id_ex_rt) fb = mem_wb_val;
      if (ex_fwd_ok && ex_mem_dst == id_ex_rs) fa = ex_mem_alu;
      if (ex_fwd_ok && ex_mem_dst == id_ex_rt) fb = ex_mem_alu;
   end

   assign alu_b     = (id_ex_type == RR_ALU) ? fb : id_ex_imm;
   assign br_target = id_ex_npc + id_ex_imm;
   assign br_taken  = (id_ex_type == BRANCH) && !HALTED &&
                      ((id_ex_op == OP_BEQZ) == (fa == '0));

   pipeline_alu u_alu (
      .op     (id_ex_op),
      .a      (fa),
      .b      (alu_b),
      .result (alu_res)
   );

   // Pipeline advance, redirect, halt and async flush to bubbles
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         PC           <= '0;
         HALTED       <= 1'b0;
         TAKEN_BRANCH <= 1'b0;
         stop_fetch   <= 1'b0;
         if_id_ir     <= NOP_IR;
         if_id_npc    <= '0;
         id_ex_type   <= NOP;
         id_ex_op     <= '0;
         id_ex_rs     <= '0;
         id_ex_rt     <= '0;
         id_ex_dst    <= '0;
         id_ex_a      <= '0;
         id_ex_b      <= '0;
         id_ex_imm    <= '0;
         id_ex_npc    <= '0;
         ex_mem_type  <= NOP;
         ex_mem_dst   <= '0;
         ex_mem_alu   <= '0;
         ex_mem_b     <= '0;
         mem_wb_type  <= NOP;
         mem_wb_dst   <= '0;
         mem_wb_val   <= '0;
      end else if (!HALTED) begin
         TAKEN_BRANCH <= br_taken;
         if (br_taken) begin
            PC       <= br_target;
            if_id_ir <= NOP_IR;
         end else if (stop_fetch || id_type == HALT) begin
            stop_fetch <= 1'b1;
            if_id_ir   <= NOP_IR;
         end else begin
            if_id_ir  <= Mem[PC[9:0]];
            if_id_npc <= PC + 32'd1;
            PC        <= PC + 32'd1;
         end
         if (br_taken) begin
            id_ex_type <= NOP;
            id_ex_dst  <= '0;
         end else begin
            id_ex_type <= id_type;
            id_ex_dst  <= id_dst;
         end
         id_ex_op    <= id_op;
         id_ex_rs    <= id_rs;
         id_ex_rt    <= id_rt;
         id_ex_a     <= id_a;
         id_ex_b     <= id_b;
         id_ex_imm   <= sext(if_id_ir[IMM_HI:IMM_LO]);
         id_ex_npc   <= if_id_npc;
         ex_mem_type <= id_ex_type;
         ex_mem_dst  <= id_ex_dst;
         ex_mem_alu  <= alu_res;
         ex_mem_b    <= fb;
         mem_wb_type <= ex_mem_type;
         mem_wb_dst  <= ex_mem_dst;
         mem_wb_val  <= (ex_mem_type == LOAD) ?
                        Mem[ex_mem_alu[9:0]] : ex_mem_alu;
         if (mem_wb_type == HALT) HALTED <= 1'b1;
      end
   end

   // Architectural writes; no reset so preloaded contents persist
   always_ff @(posedge clk1) begin
      if (!HALTED && mem_wb_dst != '0)
         Reg[mem_wb_dst] <= mem_wb_val;
      if (!HALTED && ex_mem_type == STORE)
         Mem[ex_mem_alu[9:0]] <= ex_mem_b;
   end

endmodule

// File: tb/tb_pipeline_processor.sv
// Bench for pipeline_processor: directed programs plus random
// straight-line programs checked against an ISA-level interpreter.
module tb_pipeline_processor;

   logic clk1 = 1'b0;
   logic rst_n;
   logic halted;

   int total = 0;
   int bad   = 0;
   int tb_pulses = 0;
   int base_pulses;

   logic [31:0] m_reg [32];
   logic [31:0] m_mem [1024];
   int m_taken;
   int m_pc;

   pipeline_processor dut (
      .clk1   (clk1),
      .rst_n  (rst_n),
      .halted (halted)
   );

   always #5 clk1 = ~clk1;

   always @(negedge clk1) begin
      if (dut.TAKEN_BRANCH === 1'b1) tb_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_rr(int op, int rd, int rs, int rt);
      return {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction

   function automatic logic [31:0] enc_ri(int op, int rt, int rs, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   task automatic put(input logic [4:0] d, input logic [31:0] v);
      if (d != 5'd0) m_reg[d] = v;
   endtask

   // Sequential ISA interpreter: one instruction at a time, no pipeline
   task automatic model_run();
      int pc;
      int op;
      logic [31:0] ir, a, b, imm, ea;
      logic [4:0] rs, rt, rd;
      pc = 0;
      m_taken = 0;
      m_pc = -1;
      for (int s = 0; s < 4000; s++) begin
         ir  = m_mem[pc];
         op  = int'(ir[31:26]);
         rs  = ir[25:21];
         rt  = ir[20:16];
         rd  = ir[15:11];
         imm = {{16{ir[15]}}, ir[15:0]};
         a   = (rs == 0) ? 32'd0 : m_reg[rs];
         b   = (rt == 0) ? 32'd0 : m_reg[rt];
         ea  = a + imm;
         if (op == 63) begin
            m_pc = pc + 1;
            return;
         end
         pc = pc + 1;
         case (op)
            0:  put(rd, a + b);
            1:  put(rd, a - b);
            2:  put(rd, a & b);
            3:  put(rd, a | b);
            4:  put(rd, 32'($signed(a) < $signed(b)));
            5:  put(rd, a * b);
            8:  put(rt, m_mem[ea[9:0]]);
            9:  m_mem[ea[9:0]] = b;
            10: put(rt, a + imm);
            11: put(rt, a - imm);
            12: put(rt, 32'($signed(a) < $signed(imm)));
            13: if (a != 0) begin pc = pc + $signed(imm); m_taken++; end
            14: if (a == 0) begin pc = pc + $signed(imm); m_taken++; end
            default: ;
         endcase
      end
   endtask

   task automatic push();
      @(negedge clk1);
      rst_n = 1'b0;
      for (int r = 0; r < 32; r++) dut.Reg[r] = m_reg[r];
      for (int k = 0; k < 1024; k++) dut.Mem[k] = m_mem[k];
   endtask

   task automatic start_and_wait(input string tag);
      int n;
      base_pulses = tb_pulses;
      @(negedge clk1);
      rst_n = 1'b1;
      n = 0;
      while (halted !== 1'b1 && n < 3000) begin
         @(negedge clk1);
         n++;
      end
      check({tag, ":halted"}, {31'd0, halted}, 32'd1);
   endtask

   task automatic compare_all(input string tag);
      for (int r = 0; r < 32; r++)
         check($sformatf("%s:R%0d", tag, r), dut.Reg[r], m_reg[r]);
      for (int k = 0; k < 1024; k++)
         check($sformatf("%s:M%0d", tag, k), dut.Mem[k], m_mem[k]);
      check({tag, ":pc"}, dut.PC, 32'(m_pc));
      check({tag, ":pulses"}, 32'(tb_pulses - base_pulses), 32'(m_taken));
      repeat (4) @(negedge clk1);
      check({tag, ":pc_hold"}, dut.PC, 32'(m_pc));
      check({tag, ":halt_hold"}, {31'd0, halted}, 32'd1);
   endtask

   task automatic run_prog(input string tag);
      push();
      model_run();
      start_and_wait(tag);
      compare_all(tag);
   endtask

   task automatic preload_identity();
      for (int r = 0; r < 32; r++) m_reg[r] = 32'(r);
      for (int k = 0; k < 1024; k++) m_mem[k] = 32'd0;
   endtask

   task automatic async_reset_check(input string tag);
      @(negedge clk1);
      #2 rst_n = 1'b0;
      #1;
      check({tag, ":pc0"}, dut.PC, 32'd0);
      check({tag, ":halted0"}, {31'd0, halted}, 32'd0);
      check({tag, ":tb0"}, {31'd0, dut.TAKEN_BRANCH}, 32'd0);
   endtask

   // Random forward-branching program; a filler follows every load
   task automatic gen_random(input int n);
      int a;
      int kind;
      for (int k = 0; k < 1024; k++) m_mem[k] = $urandom;
      m_reg[0] = 32'd0;
      for (int r = 1; r < 32; r++)
         m_reg[r] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      a = 0;
      while (a < n) begin
         kind = int'($urandom_range(0, 9));
         if (kind <= 3) begin
            m_mem[a] = enc_rr(int'($urandom_range(0, 5)),
                              int'($urandom_range(0, 31)),
                              int'($urandom_range(0, 31)),
                              int'($urandom_range(0, 31)));
            a++;
         end else if (kind <= 5) begin
            m_mem[a] = enc_ri(int'($urandom_range(10, 12)),
                              int'($urandom_range(0, 31)),
                              int'($urandom_range(0, 31)),
                              int'($urandom_range(0, 65535)));
            a++;
         end else if (kind == 6 && a + 1 < n) begin
            m_mem[a] = enc_ri(8, int'($urandom_range(0, 31)), 0,
                              int'($urandom_range(512, 1023)));
            m_mem[a + 1] = {6'd6, 26'($urandom)};
            a += 2;
         end else if (kind == 7) begin
            m_mem[a] = enc_ri(9, int'($urandom_range(0, 31)), 0,
                              int'($urandom_range(512, 1023)));
            a++;
         end else if (kind == 8) begin
            m_mem[a] = enc_ri(int'($urandom_range(13, 14)), 0,
                              int'($urandom_range(0, 31)),
                              int'($urandom_range(0, n - a - 1)));
            a++;
         end else begin
            m_mem[a] = {6'($urandom_range(15, 62)), 26'($urandom)};
            a++;
         end
      end
      m_mem[n] = 32'hfc00_0000;
   endtask

   initial begin
      rst_n = 1'b0;
      @(negedge clk1);
      check("reset:pc", dut.PC, 32'd0);
      check("reset:halted", {31'd0, halted}, 32'd0);
      check("reset:tb", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

      preload_identity();
      m_mem[0] = 32'h2801000a;
      m_mem[1] = 32'h28020014;
      m_mem[2] = 32'h28030019;
      m_mem[3] = 32'h0ce77800;
      m_mem[4] = 32'h0ce77800;
      m_mem[5] = 32'h00222000;
      m_mem[6] = 32'h0ce77800;
      m_mem[7] = 32'h00832800;
      m_mem[8] = 32'hfc000000;
      run_prog("t23");
      check("t23:R0", dut.Reg[0], 32'd0);
      check("t23:R1", dut.Reg[1], 32'd10);
      check("t23:R2", dut.Reg[2], 32'd20);
      check("t23:R3", dut.Reg[3], 32'd25);
      check("t23:R4", dut.Reg[4], 32'd30);
      check("t23:R5", dut.Reg[5], 32'd55);
      check("t23:PC", dut.PC, 32'd9);

      preload_identity();
      m_mem[0] = enc_ri(10, 1, 0, 5);
      m_mem[1] = enc_rr(0, 2, 1, 1);
      m_mem[2] = enc_rr(1, 3, 2, 1);
      m_mem[3] = 32'hfc00_0000;
      run_prog("t24");
      check("t24:R2", dut.Reg[2], 32'd10);
      check("t24:R3", dut.Reg[3], 32'd5);

      preload_identity();
      m_mem[120] = 32'd85;
      m_mem[0] = enc_ri(8, 2, 0, 120);
      m_mem[1] = enc_rr(3, 7, 7, 7);
      m_mem[2] = enc_ri(10, 3, 2, 45);
      m_mem[3] = enc_ri(9, 3, 0, 121);
      m_mem[4] = 32'hfc00_0000;
      run_prog("t25");
      check("t25:R3", dut.Reg[3], 32'd130);
      check("t25:M121", dut.Mem[121], 32'd130);

      preload_identity();
      m_mem[0] = enc_ri(10, 1, 0, 3);
      m_mem[1] = enc_ri(11, 1, 1, 1);
      m_mem[2] = enc_ri(13, 0, 1, -2);
      m_mem[3] = enc_ri(10, 2, 0, 7);
      m_mem[4] = 32'hfc00_0000;
      run_prog("t26");
      check("t26:R1", dut.Reg[1], 32'd0);
      check("t26:R2", dut.Reg[2], 32'd7);
      check("t26:pulses", 32'(tb_pulses - base_pulses), 32'd2);
      check("t26:PC", dut.PC, 32'd5);

      async_reset_check("t27halt");
      model_run();
      start_and_wait("t27rerun");
      compare_all("t27rerun");

      base_pulses = tb_pulses;
      @(negedge clk1);
      rst_n = 1'b1;
      repeat (6) @(negedge clk1);
      async_reset_check("t27mid");
      check("t27mid:M2", dut.Mem[2], m_mem[2]);
      check("t27mid:R9", dut.Reg[9], 32'd9);
      model_run();
      start_and_wait("t27again");
      compare_all("t27again");
      check("t27again:R1", dut.Reg[1], 32'd0);
      check("t27again:R2", dut.Reg[2], 32'd7);

      preload_identity();
      m_mem[0] = enc_ri(10, 0, 0, 9);
      m_mem[1] = 32'hfc00_0000;
      run_prog("t27r0");
      check("t27r0:R0", dut.Reg[0], 32'd0);

      for (int t = 0; t < 6; t++) begin
         gen_random(40);
         run_prog($sformatf("rnd%0d", t));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_processor.md
PIPELINE_PROCESSOR -- requirements
Module: pipeline_processor

Interface
REQ-001 SHALL have no parameters: register file 32x32, unified memory 1024x32, word-addressed.
REQ-002 clk1  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 halted  output  1  mirrors internal HALTED flag.
REQ-005 SHALL expose hierarchically accessible state: Reg[0:31] (32b), Mem[0:1023] (32b), PC (32b), HALTED (1b), TAKEN_BRANCH (1b), so a bench or loader can preload Reg/Mem and inspect results.

Function
REQ-006 SHALL implement a 5-stage pipeline IF, ID, EX, MEM, WB with one stage per clk1 cycle; an instruction fetched in cycle n writes its register result at the end of cycle n+4.
REQ-007 Instruction format: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0], sign-extended to 32b.
REQ-008 Opcodes: ADD=0, SUB=1, AND=2, OR=3, SLT=4, MUL=5, LW=8, SW=9, ADDI=10, SUBI=11, SLTI=12, BNEQZ=13, BEQZ=14, HLT=63; any other opcode behaves as a NOP.
REQ-009 RR ops: rd <- rs op rt; RI ops: rt <- rs op imm; SLT/SLTI signed compare, result 1 or 0; MUL keeps low 32 bits; all add/sub wrap modulo 2^32.
REQ-010 LW: rt <- Mem[(rs+imm)[9:0]]; SW: Mem[(rs+imm)[9:0]] <- rt, written in MEM stage.
REQ-011 IF: fetch Mem[PC[9:0]], PC <- PC+1 (NPC) unless redirected or halted.
REQ-012 Branches resolved in EX: BEQZ taken if rs==0, BNEQZ taken if rs!=0; target = NPC + imm (NPC = branch address + 1).
REQ-013 Taken branch: PC <- target at that edge, the two younger instructions (in IF/ID and ID/EX) converted to NOPs, TAKEN_BRANCH high for exactly that one cycle; squashed instructions never write Reg or Mem.
REQ-014 SHALL forward EX/MEM and MEM/WB results to EX operands (youngest wins); register file write-through, same-cycle write visible to ID read.
REQ-015 No load-use interlock: the instruction immediately after LW SHALL NOT consume its rt; software inserts one instruction.
REQ-016 R0 reads always 0; writes to R0 discarded.
REQ-017 HLT decoded in ID: fetching stops, PC holds, younger instructions are NOPs; older instructions complete.
REQ-018 HLT reaching WB sets HALTED=1; thereafter no Reg, Mem or PC changes until reset.

Reset
REQ-019 rst_n low SHALL immediately force PC=0, HALTED=0, TAKEN_BRANCH=0, halted=0 and all pipeline registers to NOP.
REQ-020 Reg and Mem SHALL NOT be reset (preloaded content preserved); reset mid-operation discards in-flight instructions and execution restarts at address 0 after release.

Structure
REQ-021 Shared package holds opcode constants, stage instruction-type enum (RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP) and field bit positions.
REQ-022 One natural sub-module: pipeline_alu (combinational, opcode + two operands -> 32b result); all else in pipeline_processor.

Verification
REQ-023 Reg[k]=k preload; Mem[0..8]=2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 -> R0=0, R1=10, R2=20, R3=25, R4=30, R5=55, halted=1, PC frozen.
REQ-024 ADDI R1,R0,5; ADD R2,R1,R1; SUB R3,R2,R1; HLT (no NOPs) -> R2=10, R3=5 via forwarding.
REQ-025 Mem[120]=85; LW R2,120(R0); OR R7,R7,R7; ADDI R3,R2,45; SW R3,121(R0); HLT -> R3=130, Mem[121]=130.
REQ-026 ADDI R1,R0,3; SUBI R1,R1,1; BNEQZ R1,-2; ADDI R2,R0,7; HLT -> R1=0, R2=7, TAKEN_BRANCH pulses twice, squashed slots write nothing.
REQ-027 ADDI R0,R0,9; HLT -> R0 stays 0; rst_n pulsed low mid-program -> PC=0, halted=0 at once, Reg/Mem retained, program reruns to same final values.
